// File: rtl/cop1_scoreboard_rf.sv
// COP1 register file with per-register busy scoreboard, WAW issue stall,
// write-through bypass and FCC bits. Optional flush port: COP1_FLUSH_EN.
module cop1_scoreboard_rf #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_FCC  = 8,
  parameter int MAX_PEND = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = (NUM_FCC > 1) ? $clog2(NUM_FCC) : 1,
  localparam int PW = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_dst,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fcc_we,
  input  logic [CW-1:0]     fcc_idx,
  input  logic              fcc_val,
  input  logic [CW-1:0]     fcc_rd_idx,
  output logic              fcc_rd,
  output logic [PW-1:0]     pend_cnt,
  output logic              wb_err,
  output logic              ld_conflict
`ifdef COP1_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam logic [AW:0]   NR = (AW+1)'(NUM_REGS);
  localparam logic [CW:0]   NF = (CW+1)'(NUM_FCC);
  localparam logic [PW-1:0] MP = PW'(MAX_PEND);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_FCC-1:0]  fcc;
  logic [PW-1:0]       pend_nxt;

  logic fl;
  logic wb_v;
  logic wb_busy;
  logic wb_clr;
  logic acc;
  logic ld_drop;
  logic ld_ok;

`ifdef COP1_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  function automatic logic in_r(input logic [AW-1:0] a);
    return {1'b0, a} < NR;
  endfunction

  function automatic logic in_f(input logic [CW-1:0] a);
    return {1'b0, a} < NF;
  endfunction

  function automatic logic bsy(input logic [AW-1:0] a);
    return in_r(a) && busy[a];
  endfunction

  // A flushed writeback is invisible everywhere, bypass included.
  assign wb_v    = wb_valid && !fl;
  assign wb_busy = bsy(wb_dst);
  assign wb_clr  = wb_v && wb_busy;

  assign issue_ready = !fl
    && (!bsy(issue_dst) || (wb_v && wb_dst == issue_dst))
    && (pend_cnt < MP || wb_clr);
  assign acc = issue_valid && issue_ready;

  assign ld_drop = ld_valid
    && (bsy(ld_dst) || (wb_v && wb_dst == ld_dst));
  assign ld_ok = ld_valid && !ld_drop && in_r(ld_dst);

  always_comb begin
    rs_data = '0;
    if (wb_v && wb_dst == rs_addr)
      rs_data = wb_data;
    else if (ld_ok && ld_dst == rs_addr)
      rs_data = ld_data;
    else if (in_r(rs_addr))
      rs_data = regs[rs_addr];
  end

  always_comb begin
    rt_data = '0;
    if (wb_v && wb_dst == rt_addr)
      rt_data = wb_data;
    else if (ld_ok && ld_dst == rt_addr)
      rt_data = ld_data;
    else if (in_r(rt_addr))
      rt_data = regs[rt_addr];
  end

  assign rs_busy = bsy(rs_addr);
  assign rt_busy = bsy(rt_addr);

  always_comb begin
    fcc_rd = 1'b0;
    if (in_f(fcc_rd_idx)) begin
      if (fcc_we && fcc_idx == fcc_rd_idx)
        fcc_rd = fcc_val;
      else
        fcc_rd = fcc[fcc_rd_idx];
    end
  end

  // Issue is applied after the clear so a same-register pair stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_clr)
      busy_nxt[wb_dst] = 1'b0;
    if (acc && in_r(issue_dst))
      busy_nxt[issue_dst] = 1'b1;
    if (fl)
      busy_nxt = '0;
  end

  always_comb begin
    pend_nxt = pend_cnt;
    if (acc && !wb_clr && pend_cnt < MP)
      pend_nxt = pend_cnt + 1'b1;
    else if (!acc && wb_clr && pend_cnt != '0)
      pend_nxt = pend_cnt - 1'b1;
    if (fl)
      pend_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy        <= '0;
      fcc         <= '0;
      pend_cnt    <= '0;
      wb_err      <= 1'b0;
      ld_conflict <= 1'b0;
    end else begin
      wb_err      <= wb_v && !wb_busy;
      ld_conflict <= ld_drop;
      if (wb_v && in_r(wb_dst))
        regs[wb_dst] <= wb_data;
      if (ld_ok)
        regs[ld_dst] <= ld_data;
      if (fcc_we && in_f(fcc_idx))
        fcc[fcc_idx] <= fcc_val;
      busy     <= busy_nxt;
      pend_cnt <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_cop1_scoreboard_rf.sv
// Directed bench for cop1_scoreboard_rf: scoreboard, bypass, load
// conflicts, FCC and (with COP1_FLUSH_EN) flush.
module tb_cop1_scoreboard_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        rs_busy, rt_busy;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic [4:0]  ld_dst;
  logic [31:0] ld_data;
  logic        fcc_we;
  logic [2:0]  fcc_idx;
  logic        fcc_val;
  logic [2:0]  fcc_rd_idx;
  logic        fcc_rd;
  logic [2:0]  pend_cnt;
  logic        wb_err;
  logic        ld_conflict;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;

  cop1_scoreboard_rf dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
    .fcc_we(fcc_we), .fcc_idx(fcc_idx), .fcc_val(fcc_val),
    .fcc_rd_idx(fcc_rd_idx), .fcc_rd(fcc_rd),
    .pend_cnt(pend_cnt), .wb_err(wb_err),
    .ld_conflict(ld_conflict)
`ifdef COP1_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic fail(input string tag);
    n_err++;
    $error("FAIL %s", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; wb_valid = 0; ld_valid = 0;
    fcc_we = 0; flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle();
    rs_addr = 0; rt_addr = 0; issue_dst = 0;
    wb_dst = 0; wb_data = 0; ld_dst = 0; ld_data = 0;
    fcc_idx = 0; fcc_val = 0; fcc_rd_idx = 0;
    tick(); tick();
    rst = 0;
    #1;
    n_cmp++; if (pend_cnt !== 3'd0) fail("rst_pend");
    n_cmp++; if (issue_ready !== 1'b1) fail("rst_ready");
    n_cmp++; if (wb_err !== 1'b0) fail("rst_wb_err");
    n_cmp++; if (ld_conflict !== 1'b0) fail("rst_ld_conf");
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      n_cmp++; if (rs_data !== 32'h0) fail("rst_rs");
      n_cmp++; if (rt_data !== 32'h0) fail("rst_rt");
    end
    for (int i = 0; i < 8; i++) begin
      fcc_rd_idx = 3'(i);
      #1;
      n_cmp++; if (fcc_rd !== 1'b0) fail("rst_fcc");
    end

    rs_addr = 5; issue_valid = 1; issue_dst = 5;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) fail("iss5_ready");
    tick();
    n_cmp++; if (issue_ready !== 1'b0) fail("waw_ready");
    n_cmp++; if (rs_busy !== 1'b1) fail("waw_busy");
    n_cmp++; if (pend_cnt !== 3'd1) fail("waw_pend");
    tick();
    wb_valid = 1; wb_dst = 5; wb_data = 32'h3F80_0000;
    #1;
    n_cmp++; if (rs_data !== 32'h3F80_0000) fail("byp_rs");
    n_cmp++; if (issue_ready !== 1'b1) fail("byp_ready");
    tick();
    idle();
    #1;
    n_cmp++; if (pend_cnt !== 3'd1) fail("reiss_pend");
    n_cmp++; if (rs_busy !== 1'b1) fail("reiss_busy");
    n_cmp++; if (rs_data !== 32'h3F80_0000) fail("reiss_data");
    n_cmp++; if (wb_err !== 1'b0) fail("reiss_wb_err");
    wb_valid = 1; wb_dst = 5; wb_data = 32'h1111_1111;
    tick();
    idle();
    #1;
    n_cmp++; if (pend_cnt !== 3'd0) fail("clr5_pend");
    n_cmp++; if (rs_busy !== 1'b0) fail("clr5_busy");
    n_cmp++; if (rs_data !== 32'h1111_1111) fail("clr5_data");

    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1; issue_dst = 5'(i);
      tick();
    end
    issue_dst = 6;
    #1;
    n_cmp++; if (pend_cnt !== 3'd4) fail("full_pend");
    n_cmp++; if (issue_ready !== 1'b0) fail("full_ready");
    wb_valid = 1; wb_dst = 1; wb_data = 32'hA;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) fail("full_wb_ready");
    tick();
    idle();
    rs_addr = 6; rt_addr = 1;
    #1;
    n_cmp++; if (pend_cnt !== 3'd4) fail("full_pend2");
    n_cmp++; if (rs_busy !== 1'b1) fail("busy6");
    n_cmp++; if (rt_busy !== 1'b0) fail("busy1");
    n_cmp++; if (rt_data !== 32'hA) fail("data1");
    wb_valid = 1; wb_dst = 2; tick();
    wb_dst = 3; tick();
    wb_dst = 4; tick();
    wb_dst = 6; tick();
    idle();
    #1;
    n_cmp++; if (pend_cnt !== 3'd0) fail("drain_pend");
    n_cmp++; if (wb_err !== 1'b0) fail("drain_wb_err");

    issue_valid = 1; issue_dst = 7;
    tick();
    idle();
    ld_valid = 1; ld_dst = 7; ld_data = 32'h4000_0000; rs_addr = 7;
    #1;
    n_cmp++; if (rs_data !== 32'h0) fail("ldc_byp");
    tick();
    idle();
    #1;
    n_cmp++; if (ld_conflict !== 1'b1) fail("ldc_pulse");
    n_cmp++; if (rs_data !== 32'h0) fail("ldc_data");
    n_cmp++; if (rs_busy !== 1'b1) fail("ldc_busy");
    wb_valid = 1; wb_dst = 7; wb_data = 32'h77;
    tick();
    idle();
    #1;
    n_cmp++; if (ld_conflict !== 1'b0) fail("ldc_end");

    ld_valid = 1; ld_dst = 8; ld_data = 32'h1234_5678; rs_addr = 8;
    #1;
    n_cmp++; if (rs_data !== 32'h1234_5678) fail("ld_byp");
    tick();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h1234_5678) fail("ld_stored");
    n_cmp++; if (ld_conflict !== 1'b0) fail("ld_noconf");

    ld_valid = 1; ld_dst = 10; ld_data = 32'hBAD;
    wb_valid = 1; wb_dst = 10; wb_data = 32'h600D; rs_addr = 10;
    #1;
    n_cmp++; if (rs_data !== 32'h600D) fail("ldwb_byp");
    tick();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h600D) fail("ldwb_data");
    n_cmp++; if (ld_conflict !== 1'b1) fail("ldwb_conf");
    n_cmp++; if (wb_err !== 1'b1) fail("ldwb_err");

    wb_valid = 1; wb_dst = 9; wb_data = 32'h99; rt_addr = 9;
    tick();
    idle();
    #1;
    n_cmp++; if (wb_err !== 1'b1) fail("wberr_pulse");
    n_cmp++; if (pend_cnt !== 3'd0) fail("wberr_pend");
    n_cmp++; if (rt_data !== 32'h99) fail("wberr_data");
    tick();
    n_cmp++; if (wb_err !== 1'b0) fail("wberr_end");

    fcc_we = 1; fcc_idx = 3; fcc_val = 1; fcc_rd_idx = 3;
    #1;
    n_cmp++; if (fcc_rd !== 1'b1) fail("fcc_byp");
    fcc_rd_idx = 2;
    #1;
    n_cmp++; if (fcc_rd !== 1'b0) fail("fcc_other");
    tick();
    idle();
    fcc_rd_idx = 3;
    #1;
    n_cmp++; if (fcc_rd !== 1'b1) fail("fcc_stored");

    issue_valid = 1; issue_dst = 12;
    tick();
    idle();
    n_cmp++; if (pend_cnt !== 3'd1) fail("mid_pend");
    rst = 1;
    tick();
    rst = 0;
    rs_addr = 12; rt_addr = 9;
    #1;
    n_cmp++; if (pend_cnt !== 3'd0) fail("mrst_pend");
    n_cmp++; if (rs_busy !== 1'b0) fail("mrst_busy");
    n_cmp++; if (rt_data !== 32'h0) fail("mrst_data");
    n_cmp++; if (fcc_rd !== 1'b0) fail("mrst_fcc");

`ifdef COP1_FLUSH_EN
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1; issue_dst = 5'(i);
      tick();
    end
    n_cmp++; if (pend_cnt !== 3'd3) fail("fl_pend3");
    issue_dst = 4; flush = 1;
    wb_valid = 1; wb_dst = 1; wb_data = 32'hDEAD; rs_addr = 1;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) fail("fl_ready");
    n_cmp++; if (rs_data !== 32'h0) fail("fl_nobyp");
    tick();
    idle();
    rt_addr = 4;
    #1;
    n_cmp++; if (pend_cnt !== 3'd0) fail("fl_pend");
    n_cmp++; if (rs_busy !== 1'b0) fail("fl_busy1");
    n_cmp++; if (rt_busy !== 1'b0) fail("fl_busy4");
    n_cmp++; if (rs_data !== 32'h0) fail("fl_data1");
    n_cmp++; if (wb_err !== 1'b0) fail("fl_wb_err");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
